// File: rtl/pueo_trig_merge.sv
// Merges RF/ext/PPS/soft trigger sources into one stream: edge-detects each source's valid level,
// arbitrates by fixed priority (lowest index wins) and enforces a global holdoff between grants.
module pueo_trig_merge #(
    parameter int unsigned NSRC      = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                      sysclk_i,
    input  logic                      sysclk_rst_i,
    input  logic                      running_i,
    input  logic [15:0]               holdoff_i,
    input  logic [NSRC*12-1:0]        src_addr_i,
    input  logic [NSRC*8-1:0]         src_meta_i,
    input  logic [NSRC-1:0]           src_valid_i,
    input  logic [NSRC-1:0]           src_en_i,
    output logic [11:0]               m_trig_addr_o,
    output logic [7:0]                m_trig_meta_o,
    output logic [1:0]                m_trig_src_o,
    output logic                      m_trig_valid_o,
    input  logic                      m_trig_ready_i,
    output logic [NSRC*CNT_WIDTH-1:0] drop_cnt_o
);

    logic [NSRC-1:0]                valid_prev_q;
    logic                           running_q;
    logic [NSRC-1:0]                pend_q, pend_d;
    logic [NSRC-1:0][11:0]          pend_addr_q, pend_addr_d;
    logic [NSRC-1:0][7:0]           pend_meta_q, pend_meta_d;
    logic [NSRC-1:0][CNT_WIDTH-1:0] drop_q, drop_d;
    logic [15:0]                    hold_q, hold_d;
    logic [11:0]                    out_addr_q, out_addr_d;
    logic [7:0]                     out_meta_q, out_meta_d;
    logic [1:0]                     out_src_q, out_src_d;
    logic                           out_valid_q, out_valid_d;

    logic [NSRC-1:0] evt;
    logic [NSRC-1:0] drop;
    logic [NSRC-1:0] grant_vec;
    logic            grant;
    logic [1:0]      win_idx;

    assign evt   = src_valid_i & ~valid_prev_q & src_en_i & {NSRC{running_i}};
    assign grant = (|pend_q) && (hold_q == 16'd0) && (!out_valid_q || m_trig_ready_i);

    // Scan downward so the lowest pending index is the one left standing.
    always_comb begin
        win_idx   = 2'd0;
        grant_vec = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win_idx = 2'(i);
            end
        end
        if (grant) begin
            grant_vec[win_idx] = 1'b1;
        end
    end

    always_comb begin
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_meta_d = pend_meta_q;
        drop        = '0;
        for (int n = 0; n < NSRC; n++) begin
            if (grant_vec[n]) begin
                pend_d[n] = 1'b0;
            end
            // A pending copy is never overwritten; the newer event is counted as lost instead.
            if (evt[n]) begin
                if (pend_q[n]) begin
                    drop[n] = 1'b1;
                end else begin
                    pend_d[n]      = 1'b1;
                    pend_addr_d[n] = src_addr_i[12*n +: 12];
                    pend_meta_d[n] = src_meta_i[8*n +: 8];
                end
            end
        end
        if (!running_i) begin
            pend_d = '0;
        end
    end

    always_comb begin
        drop_d = drop_q;
        for (int n = 0; n < NSRC; n++) begin
            if (running_i && !running_q) begin
                drop_d[n] = '0;
            end else if (drop[n] && (drop_q[n] != {CNT_WIDTH{1'b1}})) begin
                drop_d[n] = drop_q[n] + 1'b1;
            end
        end
    end

    always_comb begin
        out_addr_d  = out_addr_q;
        out_meta_d  = out_meta_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        hold_d      = (hold_q != 16'd0) ? hold_q - 16'd1 : 16'd0;
        if (grant) begin
            out_addr_d  = pend_addr_q[win_idx];
            out_meta_d  = pend_meta_q[win_idx];
            out_src_d   = win_idx;
            out_valid_d = 1'b1;
            hold_d      = holdoff_i;
        end else if (m_trig_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (!running_i) begin
            out_valid_d = 1'b0;
            hold_d      = 16'd0;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            valid_prev_q <= '0;
            running_q    <= 1'b0;
            pend_q       <= '0;
            pend_addr_q  <= '0;
            pend_meta_q  <= '0;
            drop_q       <= '0;
            hold_q       <= 16'd0;
            out_addr_q   <= 12'd0;
            out_meta_q   <= 8'd0;
            out_src_q    <= 2'd0;
            out_valid_q  <= 1'b0;
        end else begin
            valid_prev_q <= src_valid_i;
            running_q    <= running_i;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_meta_q  <= pend_meta_d;
            drop_q       <= drop_d;
            hold_q       <= hold_d;
            out_addr_q   <= out_addr_d;
            out_meta_q   <= out_meta_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign m_trig_addr_o  = out_addr_q;
    assign m_trig_meta_o  = out_meta_q;
    assign m_trig_src_o   = out_src_q;
    assign m_trig_valid_o = out_valid_q;
    assign drop_cnt_o     = drop_q;

endmodule
